mem_master: RTL and testbench
=============================

# mem_master

Load/store initiator driving the single-port word memory `mem` on behalf of the Qrisc32 execute stage. It accepts one CPU access at a time (byte, halfword or word; load or store) and produces word-aligned `add_r`/`add_w`/`rd`/`wr`/`data_w` cycles. It absorbs the memory's one-cycle registered read latency and performs sub-word stores as read-modify-write. Misaligned and out-of-limit accesses are rejected before they reach memory.

## Interface
- `adr_limit`, default 64, highest legal word index; legal byte address is `<= adr_limit*4`, matching the memory's own check.
- `clk` in 1: single clock, all state on the rising edge.
- `reset_n` in 1: reset, asynchronous, active-low.
- `cpu_valid` in 1: access request; held until accepted.
- `cpu_we` in 1: 1 = store, 0 = load.
- `cpu_size` in 2: size code; 0 = byte, 1 = halfword, 2 = word, 3 = illegal.
- `cpu_sign` in 1: sign-extend sub-word loads; 0 = zero-extend.
- `cpu_addr` in 32: byte address.
- `cpu_wdata` in 32: store data, right-justified.
- `cpu_ready` out 1: combinational, `(state==IDLE) && !req`.
- `cpu_rvalid` out 1: one-cycle completion pulse for loads, stores and errors.
- `cpu_rdata` out 32: load result, valid with `cpu_rvalid`.
- `cpu_err` out 1: set with `cpu_rvalid` on rejected access.
- `add_r`, `add_w` out 32: word-aligned addresses, `[1:0]=0`.
- `data_w` out 32: write word.
- `rd`, `wr` out 1: memory strobes.
- `data_r` in 32: memory read data, registered in memory, one edge after `add_r`.
- `req` in 1: memory busy; 1 = hold.

## Operation
- Accept: edge with `cpu_valid && cpu_ready`. Latch `addr`, `size`, `sign`, `we`, `wdata`.
- Little-endian lanes: byte lane = `addr[1:0]`; halfword lane = `addr[1]`.
- Error check at accept: `size==3`; half with `addr[0]`; word with `addr[1:0]!=0`; `addr > adr_limit*4`.
  - Any error: no `rd`/`wr` issued.
  - Next cycle `cpu_rvalid=1`, `cpu_err=1`, `cpu_rdata=0`.
  - State stays IDLE.
- FSM states and transitions:
  - IDLE: word store goes to WR; load goes to RD; sub-word store goes to RMW_RD.
  - RD: `rd=1`, `add_r={addr[31:2],2'b00}`; then RD_CAP.
  - RD_CAP: on edge, capture `data_r`, extract lane, extend; pulse `cpu_rvalid`; go to IDLE.
  - RMW_RD: same as RD; then RMW_CAP.
  - RMW_CAP: on edge, merge `wdata` byte/half into `data_r` at lane; drive `wr=1`, `add_w`, `data_w`; go to WR.
  - WR: `wr=1`; on edge deassert, pulse `cpu_rvalid`; go to IDLE.
- Word store from IDLE drives `wr`, `add_w`, `data_w=wdata` directly at accept.
- `req=1` freezes the FSM and all outputs; `rd`/`wr` stay asserted. `data_r` is captured only on an edge with `req=0`.
- `cpu_valid` while `cpu_ready=0` is ignored; the CPU holds the request.
- Store completion: `cpu_rdata` unchanged, `cpu_err=0`.

## Timing
- Reset (async on `reset_n` low): state IDLE; `rd`, `wr`, `add_r`, `add_w`, `data_w`, `cpu_rvalid`, `cpu_err`, `cpu_rdata` all 0. `cpu_ready=!req`.
- Reset mid-operation aborts the access with no completion pulse. `wr` drops asynchronously; a write already sampled by memory stands.
- Accept at edge T0, with `req=0` throughout:
  - Load: `rd` high T0–T1; `cpu_rvalid` high T2–T3; next accept at T3.
  - Word store: `wr` high T0–T1; `cpu_rvalid` high T1–T2.
  - Sub-word store: `rd` T0–T1; `wr` T2–T3; `cpu_rvalid` T3–T4.
  - Error: `cpu_rvalid` and `cpu_err` high T0–T1; next accept at T1.
- Each cycle of `req=1` extends the affected phase by exactly one cycle.
- `cpu_rvalid` and `cpu_err` are single-cycle pulses, never back-to-back for one access.

## Test plan
- Load from word 5 = 0x8899AABB, `cpu_addr=0x14`, size 2: `rd=1`, `add_r=0x14`; `cpu_rvalid` two cycles later with `cpu_rdata=0x8899AABB`.
- Byte loads `addr=0x17` from 0x8899AABB: `sign=1` gives 0xFFFFFF88; `sign=0` gives 0x00000088.
- Halfword store 0x1234 at 0x16 over 0x8899AABB: `rd`, then `wr` with `add_w=0x14`, `data_w=0x1234AABB`; ack at T3.
- Word load `addr=0x13`: no `rd`/`wr`; `cpu_rvalid=1`, `cpu_err=1` after T0.
- Word store `addr=0x104` with `adr_limit=64`: same error response.
- Load with `req=1` for 2 cycles during RD: `rd` held; ack at T4 with correct data.
- `reset_n` low during RMW_CAP: outputs 0 immediately, no ack; next load works normally.

Source files
------------

// File: rtl/mem_master.sv
// Load/store initiator for the single-port word memory: one CPU access at a time,
// registered read latency absorbed, sub-word stores done as read-modify-write.
module mem_master #(
    parameter int unsigned adr_limit = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cpu_valid,
    input  logic        cpu_we,
    input  logic [1:0]  cpu_size,
    input  logic        cpu_sign,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_ready,
    output logic        cpu_rvalid,
    output logic [31:0] cpu_rdata,
    output logic        cpu_err,
    output logic [31:0] add_r,
    output logic [31:0] add_w,
    output logic [31:0] data_w,
    output logic        rd,
    output logic        wr,
    input  logic [31:0] data_r,
    input  logic        req
);
    // state   | meaning
    // IDLE    | waiting for a CPU access
    // RD      | load read strobe on the bus
    // RD_CAP  | load data arrives, extract lane and complete
    // RMW_RD  | read strobe for a sub-word store
    // RMW_CAP | merge store lane into read word, start write
    // WR      | write strobe on the bus, complete on release
    typedef enum logic [2:0] {IDLE, RD, RD_CAP, RMW_RD, RMW_CAP, WR} state_t;

    localparam logic [31:0] addr_max = 32'(adr_limit) << 2;

    state_t      state_q, state_d;
    logic        rd_q, rd_d, wr_q, wr_d;
    logic [31:0] add_r_q, add_r_d, add_w_q, add_w_d, data_w_q, data_w_d;
    logic [31:0] rdata_q, rdata_d;
    logic        rvalid_q, rvalid_d, err_q, err_d;
    logic [1:0]  lane_q, lane_d, size_q, size_d;
    logic        sign_q, sign_d;
    logic [15:0] wdata_q, wdata_d;

    logic        acc_err;
    logic [31:0] shifted, ld_val, merged;

    always_comb begin
        acc_err = 1'b0;
        case (cpu_size)
            2'd0:    acc_err = 1'b0;
            2'd1:    acc_err = cpu_addr[0];
            2'd2:    acc_err = (cpu_addr[1:0] != 2'b00);
            default: acc_err = 1'b1;
        endcase
        if (cpu_addr > addr_max) acc_err = 1'b1;
    end

    always_comb begin
        shifted = data_r >> {lane_q, 3'b000};
        case (size_q)
            2'd0:    ld_val = {{24{sign_q & shifted[7]}}, shifted[7:0]};
            2'd1:    ld_val = {{16{sign_q & shifted[15]}}, shifted[15:0]};
            default: ld_val = data_r;
        endcase
        merged = data_r;
        if (size_q == 2'd0) merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
        else                merged[{lane_q[1], 4'b0000} +: 16] = wdata_q;
    end

    assign cpu_ready = (state_q == IDLE) && !req;

    always_comb begin
        state_d  = state_q;
        rd_d     = rd_q;
        wr_d     = wr_q;
        add_r_d  = add_r_q;
        add_w_d  = add_w_q;
        data_w_d = data_w_q;
        rdata_d  = rdata_q;
        // completion pulses never stretch, even if the memory stalls afterwards
        rvalid_d = 1'b0;
        err_d    = 1'b0;
        lane_d   = lane_q;
        size_d   = size_q;
        sign_d   = sign_q;
        wdata_d  = wdata_q;
        if (!req) begin
            case (state_q)
                IDLE: begin
                    if (cpu_valid) begin
                        lane_d  = cpu_addr[1:0];
                        size_d  = cpu_size;
                        sign_d  = cpu_sign;
                        wdata_d = cpu_wdata[15:0];
                        if (acc_err) begin
                            rvalid_d = 1'b1;
                            err_d    = 1'b1;
                            rdata_d  = 32'h0;
                        end else if (cpu_we && cpu_size == 2'd2) begin
                            wr_d     = 1'b1;
                            add_w_d  = {cpu_addr[31:2], 2'b00};
                            data_w_d = cpu_wdata;
                            state_d  = WR;
                        end else begin
                            rd_d    = 1'b1;
                            add_r_d = {cpu_addr[31:2], 2'b00};
                            state_d = cpu_we ? RMW_RD : RD;
                        end
                    end
                end
                RD: begin
                    rd_d    = 1'b0;
                    state_d = RD_CAP;
                end
                RD_CAP: begin
                    rdata_d  = ld_val;
                    rvalid_d = 1'b1;
                    state_d  = IDLE;
                end
                RMW_RD: begin
                    rd_d    = 1'b0;
                    state_d = RMW_CAP;
                end
                RMW_CAP: begin
                    wr_d     = 1'b1;
                    add_w_d  = add_r_q;
                    data_w_d = merged;
                    state_d  = WR;
                end
                WR: begin
                    wr_d     = 1'b0;
                    rvalid_d = 1'b1;
                    state_d  = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            add_r_q  <= 32'h0;
            add_w_q  <= 32'h0;
            data_w_q <= 32'h0;
            rdata_q  <= 32'h0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            lane_q   <= 2'd0;
            size_q   <= 2'd0;
            sign_q   <= 1'b0;
            wdata_q  <= 16'h0;
        end else begin
            state_q  <= state_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            add_r_q  <= add_r_d;
            add_w_q  <= add_w_d;
            data_w_q <= data_w_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
            lane_q   <= lane_d;
            size_q   <= size_d;
            sign_q   <= sign_d;
            wdata_q  <= wdata_d;
        end
    end

    assign rd         = rd_q;
    assign wr         = wr_q;
    assign add_r      = add_r_q;
    assign add_w      = add_w_q;
    assign data_w     = data_w_q;
    assign cpu_rdata  = rdata_q;
    assign cpu_rvalid = rvalid_q;
    assign cpu_err    = err_q;
endmodule

// File: tb/tb_mem_master.sv
// Directed bench for mem_master against a small registered word-memory model.
module tb_mem_master;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cpu_valid = 1'b0, cpu_we = 1'b0, cpu_sign = 1'b0;
    logic [1:0]  cpu_size = 2'd0;
    logic [31:0] cpu_addr = 32'h0, cpu_wdata = 32'h0;
    logic        cpu_ready, cpu_rvalid, cpu_err, rd, wr;
    logic [31:0] cpu_rdata, add_r, add_w, data_w;
    logic [31:0] data_r = 32'h0;
    logic        req = 1'b0;

    logic        poke_en = 1'b0;
    logic [6:0]  poke_idx = 7'd0;
    logic [31:0] poke_val = 32'h0;
    logic [31:0] mem [0:127];

    int n_checks = 0;
    int n_fail = 0;

    mem_master #(.adr_limit(64)) dut (
        .clk(clk), .reset_n(reset_n),
        .cpu_valid(cpu_valid), .cpu_we(cpu_we), .cpu_size(cpu_size),
        .cpu_sign(cpu_sign), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ready(cpu_ready), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .cpu_err(cpu_err), .add_r(add_r), .add_w(add_w), .data_w(data_w),
        .rd(rd), .wr(wr), .data_r(data_r), .req(req)
    );

    always #5 clk = ~clk;

    // memory: read data registered one edge after rd, writes on the wr edge, both held by req
    always @(posedge clk) begin
        if (poke_en) mem[poke_idx] <= poke_val;
        if (!req && rd) data_r <= mem[add_r[8:2]];
        if (!req && wr) mem[add_w[8:2]] <= data_w;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic poke(input logic [6:0] idx, input logic [31:0] val);
        poke_en  = 1'b1;
        poke_idx = idx;
        poke_val = val;
        step();
        poke_en  = 1'b0;
    endtask

    // drive a request, then move to the window after the accepting edge
    task automatic issue(input logic we, input logic [1:0] size, input logic sign,
                         input logic [31:0] addr, input logic [31:0] wdata);
        cpu_valid = 1'b1;
        cpu_we    = we;
        cpu_size  = size;
        cpu_sign  = sign;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        step();
        cpu_valid = 1'b0;
    endtask

    initial begin
        #1;
        chk("rst_rd", {31'd0, rd}, 32'd0);
        chk("rst_wr", {31'd0, wr}, 32'd0);
        chk("rst_add_r", add_r, 32'h0);
        chk("rst_add_w", add_w, 32'h0);
        chk("rst_data_w", data_w, 32'h0);
        chk("rst_rvalid", {31'd0, cpu_rvalid}, 32'd0);
        chk("rst_err", {31'd0, cpu_err}, 32'd0);
        chk("rst_rdata", cpu_rdata, 32'h0);
        chk("rst_ready", {31'd0, cpu_ready}, 32'd1);
        req = 1'b1;
        #1;
        chk("rst_ready_req", {31'd0, cpu_ready}, 32'd0);
        req = 1'b0;
        step();
        poke(7'd5, 32'h8899AABB);
        poke(7'd64, 32'hCAFEF00D);
        reset_n = 1'b1;
        step();

        // word load from word 5
        issue(1'b0, 2'd2, 1'b0, 32'h14, 32'h0);
        chk("ld_rd_t0", {31'd0, rd}, 32'd1);
        chk("ld_add_r", add_r, 32'h14);
        chk("ld_ready_busy", {31'd0, cpu_ready}, 32'd0);
        step();
        chk("ld_rd_t1", {31'd0, rd}, 32'd0);
        chk("ld_rvalid_t1", {31'd0, cpu_rvalid}, 32'd0);
        step();
        chk("ld_rvalid_t2", {31'd0, cpu_rvalid}, 32'd1);
        chk("ld_rdata", cpu_rdata, 32'h8899AABB);
        chk("ld_err", {31'd0, cpu_err}, 32'd0);
        chk("ld_ready_t2", {31'd0, cpu_ready}, 32'd1);

        // byte loads from lane 3, signed then unsigned
        issue(1'b0, 2'd0, 1'b1, 32'h17, 32'h0);
        chk("lb_add_r", add_r, 32'h14);
        step();
        step();
        chk("lb_s_rvalid", {31'd0, cpu_rvalid}, 32'd1);
        chk("lb_s_rdata", cpu_rdata, 32'hFFFFFF88);
        issue(1'b0, 2'd0, 1'b0, 32'h17, 32'h0);
        chk("lb_pulse_single", {31'd0, cpu_rvalid}, 32'd0);
        step();
        step();
        chk("lb_u_rdata", cpu_rdata, 32'h00000088);

        // halfword store as read-modify-write
        issue(1'b1, 2'd1, 1'b0, 32'h16, 32'h00001234);
        chk("sh_rd_t0", {31'd0, rd}, 32'd1);
        chk("sh_wr_t0", {31'd0, wr}, 32'd0);
        step();
        chk("sh_rd_t1", {31'd0, rd}, 32'd0);
        chk("sh_wr_t1", {31'd0, wr}, 32'd0);
        step();
        chk("sh_wr_t2", {31'd0, wr}, 32'd1);
        chk("sh_add_w", add_w, 32'h14);
        chk("sh_data_w", data_w, 32'h1234AABB);
        chk("sh_rvalid_t2", {31'd0, cpu_rvalid}, 32'd0);
        step();
        chk("sh_wr_t3", {31'd0, wr}, 32'd0);
        chk("sh_rvalid_t3", {31'd0, cpu_rvalid}, 32'd1);
        chk("sh_err", {31'd0, cpu_err}, 32'd0);
        chk("sh_rdata_keep", cpu_rdata, 32'h00000088);
        chk("sh_mem", mem[5], 32'h1234AABB);

        // misaligned word load
        issue(1'b0, 2'd2, 1'b0, 32'h13, 32'h0);
        chk("mis_rd", {31'd0, rd}, 32'd0);
        chk("mis_wr", {31'd0, wr}, 32'd0);
        chk("mis_rvalid", {31'd0, cpu_rvalid}, 32'd1);
        chk("mis_err", {31'd0, cpu_err}, 32'd1);
        chk("mis_rdata", cpu_rdata, 32'h0);
        chk("mis_ready", {31'd0, cpu_ready}, 32'd1);

        // out-of-limit word store, issued back-to-back after the error
        issue(1'b1, 2'd2, 1'b0, 32'h104, 32'h11112222);
        chk("lim_wr", {31'd0, wr}, 32'd0);
        chk("lim_rvalid", {31'd0, cpu_rvalid}, 32'd1);
        chk("lim_err", {31'd0, cpu_err}, 32'd1);
        step();
        chk("lim_rvalid_drop", {31'd0, cpu_rvalid}, 32'd0);
        chk("lim_err_drop", {31'd0, cpu_err}, 32'd0);

        // illegal size code
        issue(1'b0, 2'd3, 1'b0, 32'h14, 32'h0);
        chk("sz3_rd", {31'd0, rd}, 32'd0);
        chk("sz3_err", {31'd0, cpu_err}, 32'd1);
        step();

        // highest legal address
        issue(1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
        chk("edge_rd", {31'd0, rd}, 32'd1);
        step();
        step();
        chk("edge_rvalid", {31'd0, cpu_rvalid}, 32'd1);
        chk("edge_err", {31'd0, cpu_err}, 32'd0);
        chk("edge_rdata", cpu_rdata, 32'hCAFEF00D);

        // word store
        issue(1'b1, 2'd2, 1'b0, 32'h20, 32'hDEADBEEF);
        chk("sw_wr_t0", {31'd0, wr}, 32'd1);
        chk("sw_rd_t0", {31'd0, rd}, 32'd0);
        chk("sw_add_w", add_w, 32'h20);
        chk("sw_data_w", data_w, 32'hDEADBEEF);
        step();
        chk("sw_wr_t1", {31'd0, wr}, 32'd0);
        chk("sw_rvalid_t1", {31'd0, cpu_rvalid}, 32'd1);
        chk("sw_mem", mem[8], 32'hDEADBEEF);

        // load with the memory busy for two cycles during RD
        issue(1'b0, 2'd2, 1'b0, 32'h14, 32'h0);
        req = 1'b1;
        step();
        chk("stall_rd_t1", {31'd0, rd}, 32'd1);
        step();
        chk("stall_rd_t2", {31'd0, rd}, 32'd1);
        req = 1'b0;
        step();
        chk("stall_rd_t3", {31'd0, rd}, 32'd0);
        chk("stall_rvalid_t3", {31'd0, cpu_rvalid}, 32'd0);
        step();
        chk("stall_rvalid_t4", {31'd0, cpu_rvalid}, 32'd1);
        chk("stall_rdata", cpu_rdata, 32'h1234AABB);

        // reset during RMW_CAP of a byte store
        issue(1'b1, 2'd0, 1'b0, 32'h20, 32'h000000AB);
        chk("rmw_rd_t0", {31'd0, rd}, 32'd1);
        step();
        reset_n = 1'b0;
        #1;
        chk("abort_add_r", add_r, 32'h0);
        chk("abort_rdata", cpu_rdata, 32'h0);
        chk("abort_ready", {31'd0, cpu_ready}, 32'd1);
        step();
        chk("abort_wr", {31'd0, wr}, 32'd0);
        chk("abort_rvalid", {31'd0, cpu_rvalid}, 32'd0);
        chk("abort_mem", mem[8], 32'hDEADBEEF);
        reset_n = 1'b1;
        step();
        issue(1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
        chk("post_rd", {31'd0, rd}, 32'd1);
        step();
        step();
        chk("post_rvalid", {31'd0, cpu_rvalid}, 32'd1);
        chk("post_rdata", cpu_rdata, 32'hDEADBEEF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
